// File: rtl/stream_checker.sv
// Stream sequence checker: accepts beats over a valid/ready handshake and flags data
// that does not follow the incrementing sequence. Optional feature: STREAM_CHECKER_BACKPRESSURE_EN.
module stream_checker #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned COUNT_BITS = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BITS-1:0]  in_data,
    output logic                  synced,
    output logic                  err,
    output logic [COUNT_BITS-1:0] err_count,
    output logic [COUNT_BITS-1:0] beat_count,
    output logic [DATA_BITS-1:0]  expected
);

    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    // A zero seed would lock the LFSR in the all-zero state.
    if (LFSR_SEED == 16'h0000) begin : g_seed_guard
        $error("stream_checker: LFSR_SEED must be nonzero");
    end

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [DATA_BITS-1:0]  expected_next;
    logic [COUNT_BITS-1:0] err_count_next;
    logic [COUNT_BITS-1:0] beat_count_next;
    logic                  synced_next;
    logic                  fire;
    logic                  match;

    assign fire  = in_valid && in_ready;
    assign match = (in_data == expected);

    // Next-state and next-output logic; only a transfer changes anything.
    always_comb begin
        state_next      = state;
        expected_next   = expected;
        err_count_next  = err_count;
        beat_count_next = beat_count;
        synced_next     = synced;
        if (fire) begin
            beat_count_next = beat_count + COUNT_BITS'(1);
            expected_next   = in_data + DATA_BITS'(1);
            synced_next     = 1'b1;
            case (state)
                SYNC: state_next = CHECK;
                CHECK, FAULT: begin
                    if (!match) begin
                        state_next = FAULT;
                        if (err_count != {COUNT_BITS{1'b1}}) begin
                            err_count_next = err_count + COUNT_BITS'(1);
                        end
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected   <= '0;
            err_count  <= '0;
            beat_count <= '0;
            synced     <= 1'b0;
            err        <= 1'b0;
        end else begin
            expected   <= expected_next;
            err_count  <= err_count_next;
            beat_count <= beat_count_next;
            synced     <= synced_next;
            err        <= (state_next == FAULT);
        end
    end

`ifdef STREAM_CHECKER_BACKPRESSURE_EN
    // Right-shifting Galois LFSR, taps 16,14,13,11; ready is its registered low bit.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            in_ready <= 1'b0;
        end else begin
            lfsr     <= lfsr_next;
            in_ready <= lfsr_next[0];
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= 1'b1;
        end
    end
`endif

endmodule
